// File: rtl/small_fifo_fwft.sv
// Single-clock staging FIFO with registered or first-word-fall-through read, occupancy-decoded status flags.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module small_fifo_fwft #(
  parameter int WIDTH                = 72,
  parameter int MAX_DEPTH_BITS       = 3,
  parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS-1,
  parameter int PROG_EMPTY_THRESHOLD = 1,
  parameter bit FALLTHROUGH          = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    nearly_full,
  output logic                    prog_full,
  output logic                    empty,
  output logic                    prog_empty,
  output logic [MAX_DEPTH_BITS:0] data_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
  localparam int PTR_W     = MAX_DEPTH_BITS;
  localparam int CNT_W     = MAX_DEPTH_BITS + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(MAX_DEPTH);
  localparam logic [CNT_W-1:0] PF_C     = CNT_W'(PROG_FULL_THRESHOLD);
  localparam logic [CNT_W-1:0] PE_C     = CNT_W'(PROG_EMPTY_THRESHOLD);

  logic [WIDTH-1:0] mem_q [MAX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             wr_ok, rd_ok;

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign data_count  = occ_q;
  assign full        = (occ_q == DEPTH_C);
  assign nearly_full = (occ_q >= (DEPTH_C - CNT_ONE));
  assign prog_full   = (occ_q >= PF_C);
  assign empty       = (occ_q == CNT_ZERO);
  assign prog_empty  = (occ_q <= PE_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok, rd_ok})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is cleared so the fall-through view shows zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  generate
    if (FALLTHROUGH) begin : g_fwft
      assign dout = mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end
      assign dout = dout_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) begin
        overflow_q <= 1'b1;
        $display("ERROR: %m: push dropped, FIFO full");
      end
      if (rd_en && !rd_ok) begin
        underflow_q <= 1'b1;
        $display("ERROR: %m: pop dropped, FIFO empty");
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_small_fifo_fwft.sv
// Directed bench: one registered-read and one fall-through instance driven by the same stimulus.
module tb_small_fifo_fwft;

  localparam int W = 72;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic E_ERR = 1'b1;
`else
  localparam logic E_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;

  logic [W-1:0] r_dout, f_dout;
  logic         r_full, r_nfull, r_pfull, r_empty, r_pempty, r_ovf, r_unf;
  logic         f_full, f_nfull, f_pfull, f_empty, f_pempty, f_ovf, f_unf;
  logic [3:0]   r_cnt, f_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  small_fifo_fwft #(.FALLTHROUGH(1'b0)) u_reg (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(r_dout), .full(r_full), .nearly_full(r_nfull), .prog_full(r_pfull),
    .empty(r_empty), .prog_empty(r_pempty), .data_count(r_cnt),
    .overflow(r_ovf), .underflow(r_unf)
  );

  small_fifo_fwft #(.FALLTHROUGH(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(f_dout), .full(f_full), .nearly_full(f_nfull), .prog_full(f_pfull),
    .empty(f_empty), .prog_empty(f_pempty), .data_count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Flags packed as {full, nearly_full, prog_full, empty, prog_empty}.
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk({tag, " r_flags"}, {67'd0, r_full, r_nfull, r_pfull, r_empty, r_pempty}, {67'd0, exp});
    chk({tag, " f_flags"}, {67'd0, f_full, f_nfull, f_pfull, f_empty, f_pempty}, {67'd0, exp});
  endtask

  task automatic chk_reset_state(input string tag);
    chk_flags(tag, 5'b00011);
    chk({tag, " r_cnt"}, {68'd0, r_cnt}, 72'd0);
    chk({tag, " f_cnt"}, {68'd0, f_cnt}, 72'd0);
    chk({tag, " r_dout"}, r_dout, 72'd0);
    chk({tag, " f_dout"}, f_dout, 72'd0);
    chk({tag, " err"}, {68'd0, r_ovf, r_unf, f_ovf, f_unf}, 72'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("reset");

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, W'(i));
      chk($sformatf("fill%0d cnt", i), {68'd0, r_cnt}, W'(i));
      chk_flags($sformatf("fill%0d", i),
                {(i == 8), (i >= 7), (i >= 7), 1'b0, (i <= 1)});
      chk($sformatf("fill%0d f_head", i), f_dout, 72'h1);
    end

    cyc(1'b1, 1'b0, 72'h99);
    chk("ovf cnt", {68'd0, r_cnt}, 72'd8);
    chk("ovf flag", {70'd0, r_ovf, f_ovf}, {70'd0, E_ERR, E_ERR});
    chk("ovf f_head", f_dout, 72'h1);
    chk("ovf r_dout", r_dout, 72'h0);

    cyc(1'b1, 1'b1, 72'h99);
    chk("fullrw cnt", {68'd0, r_cnt}, 72'd8);
    chk("fullrw r_dout", r_dout, 72'h1);
    chk("fullrw f_head", f_dout, 72'h2);
    chk_flags("fullrw", 5'b11100);

    // Queue now holds 2..8 then 0x99.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 72'h0);
      chk($sformatf("drain%0d r_dout", i), r_dout, (i < 7) ? W'(i + 2) : 72'h99);
      chk($sformatf("drain%0d cnt", i), {68'd0, r_cnt}, W'(7 - i));
      if (i < 7) begin
        chk($sformatf("drain%0d f_head", i), f_dout, (i <= 5) ? W'(i + 3) : 72'h99);
      end
    end
    chk_flags("drained", 5'b00011);

    cyc(1'b0, 1'b1, 72'h0);
    chk("unf r_dout", r_dout, 72'h99);
    chk("unf flag", {70'd0, r_unf, f_unf}, {70'd0, E_ERR, E_ERR});
    chk("unf cnt", {68'd0, r_cnt}, 72'd0);

    cyc(1'b1, 1'b0, 72'hA5);
    chk("fwft empty", {71'd0, f_empty}, 72'd0);
    chk("fwft dout", f_dout, 72'hA5);
    chk("fwft r_dout held", r_dout, 72'h99);
    cyc(1'b0, 1'b1, 72'h0);
    chk("fwft pop empty", {71'd0, f_empty}, 72'd1);
    chk("fwft pop r_dout", r_dout, 72'hA5);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, W'(256 + i));
    end
    chk("wrap pre cnt", {68'd0, r_cnt}, 72'd3);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, W'(259 + k));
      chk($sformatf("wrap%0d r_dout", k), r_dout, W'(256 + k));
      chk($sformatf("wrap%0d f_head", k), f_dout, W'(257 + k));
      chk($sformatf("wrap%0d cnt", k), {68'd0, r_cnt, f_cnt}, 72'h33);
      chk_flags($sformatf("wrap%0d", k), 5'b00000);
    end

    cyc(1'b1, 1'b0, 72'h117);
    cyc(1'b1, 1'b0, 72'h118);
    chk("pre-rst cnt", {68'd0, r_cnt}, 72'd5);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 72'h42);
    chk("post-rst cnt", {68'd0, r_cnt}, 72'd1);
    chk("post-rst f_dout", f_dout, 72'h42);
    cyc(1'b0, 1'b1, 72'h0);
    chk("post-rst r_dout", r_dout, 72'h42);
    chk_flags("post-rst", 5'b00011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
